// File: rtl/fib_seq_ctrl_if.sv
// Start/done handshake and status bundle between the Fibonacci sequencer and its requester.
interface fib_seq_ctrl_if;
  logic       start;
  logic [2:0] n;
  logic       busy;
  logic       done;
  logic [4:0] result;
  logic       err;
  logic [6:0] cycles;

  modport master (output start, n, input busy, done, result, err, cycles);
  modport slave  (input start, n, output busy, done, result, err, cycles);
endinterface

// File: rtl/fib_seq_ctrl.sv
// Depth-first Fibonacci sequencer: operand stack, decrement path and leaf accumulator.
// Optional busy-cycle counter is built only when FIB_CYCLE_COUNT_EN is defined.
module fib_seq_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  fib_seq_ctrl_if.slave bus
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SP_W = $clog2(DEPTH) + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

  typedef enum logic [2:0] {IDLE, FETCH, EVAL, PUSH2, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cur_q, cur_d;
  logic [4:0]      acc_q, acc_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [4:0]      result_q, result_d;

  logic [2:0]      stack_mem [DEPTH];
  logic            push_req, push_en;
  logic [2:0]      push_val;
  logic [AW-1:0]   wr_addr, rd_addr;
  logic            start_acc;

  assign wr_addr   = sp_q[AW-1:0];
  assign rd_addr   = AW'(sp_q - SP_W'(1));
  assign start_acc = (state_q == IDLE) && bus.start;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    acc_d    = acc_q;
    sp_d     = sp_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    result_d = result_q;
    push_req = 1'b0;
    push_en  = 1'b0;
    push_val = 3'd0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          push_req = 1'b1;
          push_val = bus.n;
          acc_d    = 5'd0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        cur_d   = stack_mem[rd_addr];
        sp_d    = (sp_q != '0) ? sp_q - SP_W'(1) : sp_q;
        state_d = EVAL;
      end
      EVAL: begin
        if (cur_q < 3'd2) begin
          acc_d = acc_q + 5'd1;
          if (sp_q == '0) begin
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            state_d = FETCH;
          end
        end else begin
          push_req = 1'b1;
          push_val = cur_q - 3'd1;
          state_d  = PUSH2;
        end
      end
      PUSH2: begin
        // cur-2 goes on top so the smaller subtree is expanded first
        push_req = 1'b1;
        push_val = cur_q - 3'd2;
        state_d  = FETCH;
      end
      DONE: begin
        done_d   = 1'b1;
        result_d = acc_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (push_req) begin
      if (sp_q == SP_FULL) begin
        err_d = 1'b1;
      end else begin
        push_en = 1'b1;
        sp_d    = sp_q + SP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cur_q    <= 3'd0;
      acc_q    <= 5'd0;
      sp_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      acc_q    <= acc_d;
      sp_q     <= sp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  // Stack contents need no reset; sp alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[wr_addr] <= push_val;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;

`ifdef FIB_CYCLE_COUNT_EN
  logic [6:0] cycles_q, cycles_d;

  function automatic logic [6:0] sat_inc7(input logic [6:0] v);
    return (v == 7'd127) ? v : v + 7'd1;
  endfunction

  always_comb begin
    cycles_d = cycles_q;
    if (start_acc) begin
      cycles_d = 7'd0;
    end else if (busy_q) begin
      cycles_d = sat_inc7(cycles_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles_q <= 7'd0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign bus.cycles = cycles_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign bus.cycles       = 7'd0;
`endif

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl with a result/latency scoreboard.
module tb_fib_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fib_seq_ctrl_if bus ();
  fib_seq_ctrl_if b2 ();

  fib_seq_ctrl #(.DEPTH(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
  fib_seq_ctrl #(.DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

`ifdef FIB_CYCLE_COUNT_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  typedef struct {
    int res;
    int lat;
    int bsy;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int fib_model(input int k);
    int a = 1;
    int b = 1;
    int t;
    for (int i = 2; i <= k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  function automatic exp_t make_exp(input int k);
    exp_t e;
    e.res = fib_model(k);
    e.bsy = 2 * e.res + 3 * (e.res - 1);
    e.lat = 1 + e.bsy;
    return e;
  endfunction

  // ign_at: edge after which a stray start (n=2) is pulsed; abort_at: edge after which rst is asserted
  task automatic run_job(input logic [2:0] nv, input int ign_at, input int abort_at);
    exp_t e;
    int   lat;
    int   bcnt;
    bit   got;
    sb.push_back(make_exp(int'(nv)));
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = nv;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.n     = ~nv;
    lat  = 0;
    bcnt = bus.busy ? 1 : 0;
    got  = 1'b0;
    while (lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == abort_at) begin
        rst = 1'b0;
        #1;
        chk("abort_busy",   32'(bus.busy),   32'd0);
        chk("abort_done",   32'(bus.done),   32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_err",    32'(bus.err),    32'd0);
        chk("abort_cycles", 32'(bus.cycles), 32'd0);
        void'(sb.pop_front());
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_done", 32'(bus.done), 32'd0);
        end
        rst = 1'b1;
        return;
      end
      bus.start = (lat == ign_at);
      bus.n     = (lat == ign_at) ? 3'd2 : ~nv;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.busy) bcnt++;
    end
    bus.start = 1'b0;
    chk($sformatf("n%0d_done_seen", nv), 32'(got), 32'd1);
    e = sb.pop_front();
    chk($sformatf("n%0d_result", nv),  32'(bus.result), 32'(e.res));
    chk($sformatf("n%0d_latency", nv), 32'(lat),        32'(e.lat));
    chk($sformatf("n%0d_busy", nv),    32'(bcnt),       32'(e.bsy));
    chk($sformatf("n%0d_err", nv),     32'(bus.err),    32'd0);
    chk($sformatf("n%0d_cycles", nv),  32'(bus.cycles), CYC_EN ? 32'(e.bsy) : 32'd0);
    @(negedge clk);
    chk($sformatf("n%0d_done_pulse", nv),  32'(bus.done),   32'd0);
    chk($sformatf("n%0d_result_hold", nv), 32'(bus.result), 32'(e.res));
  endtask

  initial begin
    int   lat;
    int   d1;
    int   d2;
    bit   got;
    exp_t e;

    rst      = 1'b0;
    bus.start = 1'b0;
    bus.n     = 3'd0;
    b2.start  = 1'b0;
    b2.n      = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(bus.busy),   32'd0);
    chk("rst_done",   32'(bus.done),   32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_err",    32'(bus.err),    32'd0);
    chk("rst_cycles", 32'(bus.cycles), 32'd0);
    rst = 1'b1;

    for (int k = 0; k < 8; k++) run_job(3'(k), -1, -1);

    run_job(3'd7, 40, -1);
    run_job(3'd7, -1, 50);
    run_job(3'd3, -1, -1);

    // start held high: the IDLE cycle after DONE accepts the next job
    sb.push_back(make_exp(0));
    sb.push_back(make_exp(0));
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = 3'd0;
    @(posedge clk);
    lat = 0;
    d1  = -1;
    d2  = -1;
    while (lat < 40 && d2 < 0) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done) begin
        e = sb.pop_front();
        chk("b2b_result", 32'(bus.result), 32'(e.res));
        if (d1 < 0) d1 = lat;
        else begin
          d2 = lat;
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    chk("b2b_first_done",  32'(d1), 32'd3);
    chk("b2b_second_done", 32'(d2), 32'd7);

    // two-entry stack overflows on the third outstanding operand
    @(negedge clk);
    b2.start = 1'b1;
    b2.n     = 3'd7;
    @(posedge clk);
    @(negedge clk);
    b2.start = 1'b0;
    lat = 0;
    got = 1'b0;
    while (lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 5) chk("ovf_err_before", 32'(b2.err), 32'd0);
      if (lat == 6) chk("ovf_err_set",    32'(b2.err), 32'd1);
      if (b2.done) begin
        got = 1'b1;
        break;
      end
    end
    chk("ovf_done_seen", 32'(got), 32'd1);
    chk("ovf_err_at_done", 32'(b2.err), 32'd1);
    repeat (2) @(negedge clk);
    chk("ovf_err_sticky", 32'(b2.err), 32'd1);
    b2.start = 1'b1;
    b2.n     = 3'd0;
    @(posedge clk);
    @(negedge clk);
    b2.start = 1'b0;
    chk("ovf_err_cleared", 32'(b2.err), 32'd0);
    lat = 0;
    got = 1'b0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (b2.done) begin
        got = 1'b1;
        break;
      end
    end
    chk("d2_n0_latency", 32'(lat), 32'd3);
    chk("d2_n0_result",  32'(b2.result), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
